// File: rtl/letter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : letter_sequencer_pkg
// Description : Shared types and constants for the letter sequencer slice.
//               Defines the letter code type, the sequencer state encoding
//               and the size of the glyph table in the downstream drawer.
// Revision    : 1.0 - initial release
// ============================================================================
package letter_sequencer_pkg;

    // One letter code as understood by the glyph drawer.
    typedef logic [5:0] letter_t;

    // Number of glyphs held in the drawer's ROM (codes 0..39).
    localparam int C_NUM_GLYPHS = 40;

    // Sequencer states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_REVEAL  = 2'd2,
        ST_SHOW    = 2'd3
    } seq_state_t;

    // Codes outside the glyph table are stored as 0 so the drawer never
    // addresses beyond its ROM.
    function automatic letter_t sanitize_letter(input letter_t code);
        return (int'(code) < C_NUM_GLYPHS) ? code : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/letter_sequencer_reveal_timer.sv
`default_nettype none
// ============================================================================
// Module      : letter_sequencer_reveal_timer
// Description : Typewriter pacing for the letter sequencer. Counts frame
//               pulses while enabled and advances the revealed-character
//               count once every REVEAL_FRAMES frames.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_clear           - zero both counters (abort)
//               i_start           - zero both counters (new reveal begins)
//               i_enable          - counting allowed (sequencer in REVEAL)
//               i_new_frame       - one-cycle start-of-frame pulse
//               o_tick            - high in the cycle revealed will advance
//               o_revealed        - number of characters currently revealed
// Revision    : 1.0 - initial release
// ============================================================================
module letter_sequencer_reveal_timer #(
    parameter int REVEAL_FRAMES = 8,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic             i_enable,
    input  logic             i_new_frame,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_revealed
);

    localparam int                   C_FRAME_W    = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [C_FRAME_W-1:0] C_LAST_FRAME = C_FRAME_W'(REVEAL_FRAMES - 1);

    logic [C_FRAME_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0]     r_revealed;
    logic                 w_advance;

    assign w_advance  = i_enable && i_new_frame;
    // The last frame of a reveal interval rolls the frame counter over and
    // exposes one more character on the same edge.
    assign o_tick     = w_advance && (r_frame_cnt == C_LAST_FRAME);
    assign o_revealed = r_revealed;

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_start) begin
            r_frame_cnt <= '0;
            r_revealed  <= '0;
        end else if (o_tick) begin
            r_frame_cnt <= '0;
            r_revealed  <= r_revealed + CNT_W'(1);
        end else if (w_advance) begin
            r_frame_cnt <= r_frame_cnt + C_FRAME_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/letter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : letter_sequencer
// Description : Holds a short string of letter codes, reveals it one
//               character at a time, and for every pixel tells the glyph
//               drawer which letter to draw and the origin of its cell.
//               Lookup outputs are registered (1-cycle latency).
// Ports       : pixel_clk_in, rst_in       - clock, sync active-high reset
//               hcount_in, vcount_in       - current pixel position
//               new_frame_in               - start-of-frame pulse
//               x_origin_in, y_origin_in   - top-left of the text line
//               wr_valid_in/wr_char_in/wr_ready_out - letter write handshake
//               commit_in                  - start revealing loaded string
//               clear_in                   - empty buffer, back to IDLE
//               select_letter_out, x_out, y_out, char_active_out
//                                          - registered cell lookup
//               busy_out                   - reveal in progress
// Revision    : 1.0 - initial release
// ============================================================================
module letter_sequencer
    import letter_sequencer_pkg::*;
#(
    parameter int MAX_CHARS     = 16,
    parameter int CHAR_PITCH    = 16,
    parameter int CHAR_HEIGHT   = 16,
    parameter int REVEAL_FRAMES = 8
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        new_frame_in,
    input  logic [10:0] x_origin_in,
    input  logic [9:0]  y_origin_in,
    input  logic        wr_valid_in,
    input  logic [5:0]  wr_char_in,
    output logic        wr_ready_out,
    input  logic        commit_in,
    input  logic        clear_in,
    output logic [5:0]  select_letter_out,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        char_active_out,
    output logic        busy_out
);

    localparam int          C_ADDR_W   = $clog2(MAX_CHARS);
    localparam int          C_CNT_W    = C_ADDR_W + 1;
    localparam int          C_PITCH_SH = $clog2(CHAR_PITCH);
    localparam logic [10:0] C_CELL_MSK = ~11'(CHAR_PITCH - 1);

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [C_CNT_W-1:0]   r_count;
    letter_t              r_buf [MAX_CHARS];

    // Control decoded from the current state
    logic                 w_wr_ready;
    logic                 w_wr;
    logic                 w_commit;
    logic                 w_timer_en;
    logic                 w_busy;

    // Reveal timer
    logic                 w_tick;
    logic [C_CNT_W-1:0]   w_revealed;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Clear overrides everything.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (clear_in) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr) begin
                        w_state_next = ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (commit_in) begin
                        w_state_next = ST_REVEAL;
                    end
                end
                ST_REVEAL: begin
                    // Leave REVEAL on the same edge that exposes the last
                    // character, so SHOW always sees revealed == count.
                    if (w_tick && ((w_revealed + C_CNT_W'(1)) == r_count)) begin
                        w_state_next = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    w_state_next = ST_SHOW;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_ready = 1'b0;
        w_commit   = 1'b0;
        w_timer_en = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_ready = (r_count < C_CNT_W'(MAX_CHARS));
            end
            ST_LOADING: begin
                // A commit closes the string; a letter offered alongside it
                // is refused rather than silently appended.
                w_wr_ready = (r_count < C_CNT_W'(MAX_CHARS)) && !commit_in;
                w_commit   = commit_in && !clear_in;
            end
            ST_REVEAL: begin
                w_timer_en = 1'b1;
                w_busy     = 1'b1;
            end
            default: begin
                w_wr_ready = 1'b0;
            end
        endcase
    end

    assign w_wr         = wr_valid_in && w_wr_ready && !clear_in;
    assign wr_ready_out = w_wr_ready;
    assign busy_out     = w_busy;

    // ------------------------------------------------------------------
    // Character count and string buffer
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in || clear_in) begin
            r_count <= '0;
        end else if (w_wr) begin
            r_count <= r_count + C_CNT_W'(1);
        end
    end

    // Buffer contents need no reset: slots at or above count are never read.
    always_ff @(posedge pixel_clk_in) begin
        if (w_wr) begin
            r_buf[r_count[C_ADDR_W-1:0]] <= sanitize_letter(wr_char_in);
        end
    end

    // ------------------------------------------------------------------
    // Reveal pacing
    // ------------------------------------------------------------------
    letter_sequencer_reveal_timer #(
        .REVEAL_FRAMES (REVEAL_FRAMES),
        .CNT_W         (C_CNT_W)
    ) u_reveal_timer (
        .clk         (pixel_clk_in),
        .rst         (rst_in),
        .i_clear     (clear_in),
        .i_start     (w_commit),
        .i_enable    (w_timer_en),
        .i_new_frame (new_frame_in),
        .o_tick      (w_tick),
        .o_revealed  (w_revealed)
    );

    // ------------------------------------------------------------------
    // Cell lookup
    // ------------------------------------------------------------------
    logic [10:0] w_dx;
    logic [10:0] w_idx;
    logic        w_x_ok;
    logic        w_idx_ok;
    logic        w_y_ok;
    logic        w_in_range;
    logic [11:0] w_y_end;

    assign w_dx     = hcount_in - x_origin_in;
    assign w_idx    = w_dx >> C_PITCH_SH;
    assign w_x_ok   = (hcount_in >= x_origin_in);
    assign w_idx_ok = (w_idx < 11'(w_revealed));
    // 12-bit bottom edge so a line near the bottom of the raster cannot wrap.
    assign w_y_end  = {2'b00, y_origin_in} + 12'(CHAR_HEIGHT);
    assign w_y_ok   = (vcount_in >= y_origin_in) && ({2'b00, vcount_in} < w_y_end);
    assign w_in_range = w_x_ok && w_idx_ok && w_y_ok;

    // Registered outputs; a clear also flushes them so an aborted reveal
    // draws nothing from the very next cycle.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in || clear_in || !w_in_range) begin
            select_letter_out <= '0;
            x_out             <= '0;
            y_out             <= '0;
            char_active_out   <= 1'b0;
        end else begin
            select_letter_out <= r_buf[w_idx[C_ADDR_W-1:0]];
            // Cell left edge is the origin plus dx rounded down to the pitch.
            x_out             <= x_origin_in + (w_dx & C_CELL_MSK);
            y_out             <= y_origin_in;
            char_active_out   <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_letter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_letter_sequencer
// Description : Scoreboard bench for letter_sequencer. A driver issues one
//               pixel/control vector per cycle, predicts the response from a
//               string-level model and queues it; a monitor pops and compares
//               after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_letter_sequencer;

    localparam int MAX   = 16;
    localparam int PITCH = 16;
    localparam int H     = 16;
    localparam int RF    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        new_frame = 1'b0;
    logic [10:0] x_origin = '0;
    logic [9:0]  y_origin = '0;
    logic        wr_valid = 1'b0;
    logic [5:0]  wr_char = '0;
    logic        wr_ready;
    logic        commit = 1'b0;
    logic        clear = 1'b0;
    logic [5:0]  sel;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic        act;
    logic        busy;

    letter_sequencer #(
        .MAX_CHARS(MAX), .CHAR_PITCH(PITCH), .CHAR_HEIGHT(H), .REVEAL_FRAMES(RF)
    ) dut (
        .pixel_clk_in      (clk),
        .rst_in            (rst),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .new_frame_in      (new_frame),
        .x_origin_in       (x_origin),
        .y_origin_in       (y_origin),
        .wr_valid_in       (wr_valid),
        .wr_char_in        (wr_char),
        .wr_ready_out      (wr_ready),
        .commit_in         (commit),
        .clear_in          (clear),
        .select_letter_out (sel),
        .x_out             (x_o),
        .y_out             (y_o),
        .char_active_out   (act),
        .busy_out          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  sel;
        logic [10:0] x;
        logic [9:0]  y;
        logic        act;
        logic        busy;
        logic        ready;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   checks = 0;
    int   errors = 0;

    // ---------------- string-level reference model ----------------
    logic [5:0] m_buf[$];
    bit         m_committed = 0;
    int         m_frames = 0;
    int         xo = 0;
    int         yo = 0;

    function automatic int m_revealed();
        int r;
        if (!m_committed) return 0;
        r = m_frames / RF;
        return (r > m_buf.size()) ? m_buf.size() : r;
    endfunction

    // One cycle of stimulus: drive, predict, advance model.
    task automatic step(input int h, input int v, input bit nf, input bit wv,
                        input int wc, input bit cm, input bit cl);
        exp_t e;
        int   rev, dx, idx;
        bit   loading, accept;
        @(negedge clk);
        hcount    = 11'(h);
        vcount    = 10'(v);
        new_frame = nf;
        wr_valid  = wv;
        wr_char   = 6'(wc);
        commit    = cm;
        clear     = cl;
        x_origin  = 11'(xo);
        y_origin  = 10'(yo);

        e   = '0;
        rev = m_revealed();
        dx  = h - xo;
        idx = (dx >= 0) ? dx / PITCH : 0;
        if (!cl && h >= xo && idx < rev && v >= yo && v < yo + H) begin
            e.act = 1'b1;
            e.sel = m_buf[idx];
            e.x   = 11'(xo + idx * PITCH);
            e.y   = 10'(yo);
        end

        if (cl) begin
            m_buf.delete();
            m_committed = 0;
            m_frames    = 0;
        end else begin
            loading = !m_committed && m_buf.size() > 0;
            accept  = wv && !m_committed && m_buf.size() < MAX && !(cm && loading);
            if (loading && cm) begin
                m_committed = 1;
                m_frames    = 0;
            end else if (m_committed && rev < m_buf.size() && nf) begin
                m_frames++;
            end
            if (accept) m_buf.push_back(6'(wc));
        end
        e.busy  = m_committed && (m_revealed() < m_buf.size());
        e.ready = !m_committed && (m_buf.size() < MAX);
        q.push_back(e);
    endtask

    task automatic idle_step(input int h, input int v);
        step(h, v, 0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_h();
        return xo - 8 + int'($urandom_range(0, MAX * PITCH + 16));
    endfunction

    function automatic int rnd_v();
        return yo - 3 + int'($urandom_range(0, H + 5));
    endfunction

    task automatic run_frames(input int nframes, input int cyc);
        for (int f = 0; f < nframes; f++) begin
            for (int c = 0; c < cyc; c++) begin
                step(rnd_h(), rnd_v(), (c == 0), 0, 0, 0, 0);
            end
        end
    endtask

    task automatic check_val(input string name, input int actual, input int req);
        checks++;
        if (actual != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, actual, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a = '{sel: sel, x: x_o, y: y_o, act: act, busy: busy, ready: wr_ready};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL lookup t=%0t actual sel=%0d x=%0d y=%0d act=%0b busy=%0b rdy=%0b required sel=%0d x=%0d y=%0d act=%0b busy=%0b rdy=%0b",
                         $time, mon_a.sel, mon_a.x, mon_a.y, mon_a.act, mon_a.busy, mon_a.ready,
                         mon_e.sel, mon_e.x, mon_e.y, mon_e.act, mon_e.busy, mon_e.ready);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int codes[3];
        codes = '{7, 12, 3};
        xo = 100;
        yo = 50;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset state, plus commit in IDLE being ignored.
        for (int i = 0; i < 10; i++) idle_step(rnd_h(), rnd_v());
        step(120, 55, 0, 0, 0, 1, 0);
        @(posedge clk); #3;
        check_val("idle_commit_busy", int'(busy), 0);
        check_val("idle_commit_ready", int'(wr_ready), 1);

        // Three-letter reveal at (100,50).
        for (int i = 0; i < 3; i++) step(rnd_h(), rnd_v(), 0, 1, codes[i], 0, 0);
        step(rnd_h(), rnd_v(), 0, 0, 0, 1, 0);
        run_frames(24, 16);
        idle_step(135, 55);
        @(posedge clk); #3;
        check_val("tp_sel", int'(sel), 3);
        check_val("tp_x", int'(x_o), 132);
        check_val("tp_y", int'(y_o), 50);
        check_val("tp_act", int'(act), 1);
        check_val("tp_show_busy", int'(busy), 0);
        // Boundary probes.
        idle_step(99, 55);
        idle_step(100, 55);
        idle_step(147, 55);
        idle_step(148, 55);
        idle_step(120, 66);
        idle_step(120, 65);
        idle_step(120, 49);
        idle_step(120, 50);

        // Overfill: 17 writes into a 16-deep buffer, then reveal all.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(rnd_h(), rnd_v(), 0, 1, $urandom_range(0, 39), 0, 0);
        @(posedge clk); #3;
        check_val("full_ready", int'(wr_ready), 0);
        step(rnd_h(), rnd_v(), 0, 0, 0, 1, 0);
        run_frames(MAX * RF, 8);
        for (int h = 96; h < 100 + MAX * PITCH + 4; h++) idle_step(h, 57);

        // Clear mid-reveal with a simultaneous write.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(rnd_h(), rnd_v(), 0, 1, $urandom_range(0, 39), 0, 0);
        step(rnd_h(), rnd_v(), 0, 0, 0, 1, 0);
        run_frames(2 * RF, 8);
        step(105, 55, 0, 1, 9, 0, 1);
        @(posedge clk); #3;
        check_val("clr_busy", int'(busy), 0);
        check_val("clr_act", int'(act), 0);
        check_val("clr_ready", int'(wr_ready), 1);
        for (int i = 0; i < 12; i++) idle_step(rnd_h(), rnd_v());

        // Randomised rounds with varying origins, gaps and early commits.
        for (int r = 0; r < 5; r++) begin
            xo = int'($urandom_range(8, 1400));
            yo = int'($urandom_range(3, 900));
            step(rnd_h(), rnd_v(), 0, 0, 0, 0, 1);
            for (int i = 0; i < int'($urandom_range(1, 18)); i++) begin
                step(rnd_h(), rnd_v(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                     $urandom_range(0, 39), ($urandom_range(0, 19) == 0), 0);
            end
            step(rnd_h(), rnd_v(), 0, ($urandom_range(0, 1) == 1), $urandom_range(0, 39), 1, 0);
            run_frames(int'($urandom_range(0, MAX * RF + 4)), 6);
            for (int i = 0; i < 40; i++) idle_step(rnd_h(), rnd_v());
        end

        repeat (2) @(posedge clk);
        #4;
        check_val("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net: the run is bounded even if something stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
